wave_capture: RTL and testbench

//  Writer side of the double-buffered 512x8 sample RAM that the waveform display reads.

---
 rtl/wave_capture_pkg.sv | 10 +
 rtl/wave_capture.sv | 62 ++++++
 tb/tb_wave_capture.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/wave_capture_pkg.sv
// wave_capture_pkg: shared state encodings and constants for the waveform capture writer.
package wave_capture_pkg;
  typedef enum logic [1:0] {
    ST_ARMED  = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_WAIT   = 2'd2
  } state_t;
  localparam int BUF_DEPTH = 256;
  localparam logic [7:0] DATA_OFFSET = 8'd128;
endpackage

// File: rtl/wave_capture.sv
// wave_capture: arms on a rising zero crossing, writes 256 samples into the free RAM half, then swaps halves when the display idles.
module wave_capture
  import wave_capture_pkg::*;
#(
  parameter int SAMPLE_W = 16,
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                new_sample_ready,
  input  logic [SAMPLE_W-1:0] new_sample_in,
  input  logic                wave_display_idle,
  output logic [ADDR_W:0]     write_address,
  output logic                write_enable,
  output logic [DATA_W-1:0]   write_sample,
  output logic                read_index
);
  state_t            state, next_state;
  logic [ADDR_W-1:0] count, next_count;
  logic              prev_neg;
  logic              sign;
  logic              trigger;
  logic              unused_low;
  assign sign          = new_sample_in[SAMPLE_W-1];
  assign trigger       = new_sample_ready & prev_neg & ~sign;
  assign write_address = {~read_index, count};
  // Adding the offset to the signed top byte maps the signed range onto 0..255.
  assign write_sample  = new_sample_in[SAMPLE_W-1 -: DATA_W] + DATA_W'(DATA_OFFSET);
  assign unused_low    = ^new_sample_in[SAMPLE_W-DATA_W-1:0];
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_ARMED;
      count      <= '0;
      prev_neg   <= 1'b0;
      read_index <= 1'b0;
    end else begin
      state <= next_state;
      count <= next_count;
      if (new_sample_ready) prev_neg <= sign;
      if (state == ST_WAIT && wave_display_idle) read_index <= ~read_index;
    end
  end
  always_comb begin
    next_state   = state;
    next_count   = count;
    write_enable = 1'b0;
    case (state)
      ST_ARMED: if (trigger) begin
        next_state = ST_ACTIVE;
        next_count = '0;
      end
      ST_ACTIVE: if (new_sample_ready) begin
        write_enable = 1'b1;
        next_count   = count + 1'b1;
        next_state   = (count == ADDR_W'(BUF_DEPTH - 1)) ? ST_WAIT : ST_ACTIVE;
      end
      ST_WAIT: next_state = wave_display_idle ? ST_ARMED : ST_WAIT;
      default: next_state = ST_ARMED;
    endcase
  end
endmodule

// File: tb/tb_wave_capture.sv
// tb_wave_capture: scoreboard of predicted RAM writes plus a boundary vector table for wave_capture.
module tb_wave_capture;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        new_sample_ready = 1'b0;
  logic [15:0] new_sample_in = '0;
  logic        wave_display_idle = 1'b0;
  logic [8:0]  write_address;
  logic        write_enable;
  logic [7:0]  write_sample;
  logic        read_index;
  int errors = 0;
  int checks = 0;
  int dut_writes = 0;
  logic [16:0] exp_q[$];
  int   m_state, m_count;
  logic m_prev, m_ri;
  typedef struct {
    logic        rdy;
    logic [15:0] s;
    logic        idl;
    logic        we;
    logic [8:0]  addr;
    logic [7:0]  data;
  } vec_t;
  vec_t tbl[8];

  wave_capture dut (
    .clk(clk), .reset(reset), .new_sample_ready(new_sample_ready),
    .new_sample_in(new_sample_in), .wave_display_idle(wave_display_idle),
    .write_address(write_address), .write_enable(write_enable),
    .write_sample(write_sample), .read_index(read_index)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Independent reference: drives one cycle of inputs and predicts the write and the next state.
  task automatic cycle(input logic rdy, input logic [15:0] s, input logic idl, input logic rst_in);
    logic [8:0] a;
    logic [7:0] d;
    @(posedge clk);
    #1;
    new_sample_ready = rdy;
    new_sample_in = s;
    wave_display_idle = idl;
    reset = rst_in;
    if (m_state == 1 && rdy) begin
      d = 8'((int'(s) >> 8) + 128);
      a = 9'(m_ri ? m_count : 256 + m_count);
      exp_q.push_back({a, d});
    end
    if (rst_in) begin
      m_state = 0; m_count = 0; m_prev = 1'b0; m_ri = 1'b0;
    end else begin
      if (m_state == 0 && rdy && m_prev && !s[15]) begin
        m_state = 1; m_count = 0;
      end else if (m_state == 1 && rdy) begin
        if (m_count == 255) m_state = 2;
        m_count = (m_count + 1) % 256;
      end else if (m_state == 2 && idl) begin
        m_ri = ~m_ri; m_state = 0;
      end
      if (rdy) m_prev = s[15];
    end
  endtask

  task automatic quiet_chk(input string name, input logic ri, input logic [8:0] addr);
    #1;
    chk({name, "_we"}, 32'(write_enable), 32'd0);
    chk({name, "_ri"}, 32'(read_index), 32'(ri));
    chk({name, "_addr"}, 32'(write_address), 32'(addr));
  endtask

  task automatic drain(input string name, input int writes);
    @(negedge clk);
    #1;
    chk({name, "_pending"}, 32'(exp_q.size()), 32'd0);
    chk({name, "_writes"}, 32'(dut_writes), 32'(writes));
    dut_writes = 0;
  endtask

  always @(negedge clk) begin
    if (write_enable) begin
      dut_writes++;
      if (exp_q.size() == 0) chk("unexpected_write", 32'(write_address), 32'h1ff_ffff);
      else begin
        logic [16:0] e;
        e = exp_q.pop_front();
        chk("wr_addr", 32'(write_address), 32'(e[16:8]));
        chk("wr_data", 32'(write_sample), 32'(e[7:0]));
      end
    end
  end

  initial begin
    m_state = 0; m_count = 0; m_prev = 1'b0; m_ri = 1'b0;
    tbl[0] = '{1'b1, 16'hFFFF, 1'b0, 1'b0, 9'h100, 8'h00};
    tbl[1] = '{1'b1, 16'h0000, 1'b0, 1'b0, 9'h100, 8'h00};
    tbl[2] = '{1'b1, 16'h8000, 1'b0, 1'b1, 9'h100, 8'h00};
    tbl[3] = '{1'b1, 16'h7FFF, 1'b0, 1'b1, 9'h101, 8'hFF};
    tbl[4] = '{1'b1, 16'h0000, 1'b0, 1'b1, 9'h102, 8'h80};
    tbl[5] = '{1'b0, 16'h1234, 1'b1, 1'b0, 9'h103, 8'h00};
    tbl[6] = '{1'b1, 16'h1234, 1'b1, 1'b1, 9'h103, 8'h92};
    tbl[7] = '{1'b1, 16'hFEDC, 1'b0, 1'b1, 9'h104, 8'h7E};
    // 1: reset then quiet
    cycle(1'b0, 16'h0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 16'h0, 1'b0, 1'b0);
      quiet_chk("idle", 1'b0, 9'h100);
    end
    // 2: trigger pair is not written, then a full ramp capture
    cycle(1'b1, 16'hF000, 1'b0, 1'b0);
    quiet_chk("trig_neg", 1'b0, 9'h100);
    cycle(1'b1, 16'h0100, 1'b0, 1'b0);
    quiet_chk("trig_pos", 1'b0, 9'h100);
    for (int i = 0; i < 256; i++) cycle(1'b1, 16'(i * 257 - 32768), 1'b0, 1'b0);
    drain("ramp", 256);
    // 4: WAIT ignores strobes until idle, then swaps halves
    for (int i = 0; i < 50; i++) begin
      cycle(1'b1, 16'(16'h8123 + i), 1'b0, 1'b0);
      quiet_chk("wait", 1'b0, 9'h100);
    end
    cycle(1'b0, 16'h0, 1'b1, 1'b0);
    quiet_chk("wait_idle", 1'b0, 9'h100);
    cycle(1'b0, 16'h0, 1'b1, 1'b0);
    quiet_chk("swapped", 1'b1, 9'h000);
    cycle(1'b1, 16'h8001, 1'b1, 1'b0);
    cycle(1'b1, 16'h0001, 1'b1, 1'b0);
    quiet_chk("armed_idle", 1'b1, 9'h000);
    for (int i = 0; i < 256; i++) cycle(1'b1, 16'($urandom), i[0], 1'b0);
    drain("second", 256);
    // 3: positive-only stream never triggers
    cycle(1'b0, 16'h0, 1'b0, 1'b1);
    for (int i = 0; i < 300; i++) cycle(1'b1, 16'h1000, 1'b0, 1'b0);
    drain("positive", 0);
    // 5: reset mid-capture
    cycle(1'b1, 16'hC000, 1'b0, 1'b0);
    cycle(1'b1, 16'h0010, 1'b0, 1'b0);
    for (int i = 0; i < 100; i++) cycle(1'b1, 16'(i * 300), 1'b0, 1'b0);
    cycle(1'b1, 16'h4321, 1'b0, 1'b1);
    cycle(1'b1, 16'h2000, 1'b0, 1'b0);
    quiet_chk("post_reset", 1'b0, 9'h100);
    cycle(1'b1, 16'h8000, 1'b0, 1'b0);
    cycle(1'b1, 16'h0000, 1'b0, 1'b0);
    cycle(1'b1, 16'h5500, 1'b0, 1'b0);
    #1;
    chk("restart_we", 32'(write_enable), 32'd1);
    chk("restart_addr", 32'(write_address), 32'h100);
    drain("midreset", 102);
    // 6: boundary data table
    cycle(1'b0, 16'h0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      cycle(tbl[i].rdy, tbl[i].s, tbl[i].idl, 1'b0);
      #1;
      chk($sformatf("tbl%0d_we", i), 32'(write_enable), 32'(tbl[i].we));
      chk($sformatf("tbl%0d_addr", i), 32'(write_address), 32'(tbl[i].addr));
      if (tbl[i].we) chk($sformatf("tbl%0d_data", i), 32'(write_sample), 32'(tbl[i].data));
    end
    drain("table", 5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
